// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage WIDTH-wide bitwise logic unit with valid/ready backpressure.
// Build option LOGIC_UNIT_POPCNT_EN: Op=111 yields popcount(A & B) instead of passing A through.

module logic_unit_slice (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);
  always_comb begin
    y = a;
    case (op)
      3'b000:  y = a & b;
      3'b001:  y = a | b;
      3'b010:  y = a ^ b;
      3'b011:  y = ~(a & b);
      3'b100:  y = ~(a | b);
      3'b101:  y = ~(a ^ b);
      3'b110:  y = a & ~b;
      default: y = a;
    endcase
  end
endmodule

module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             AllOnes
);
  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  logic [WIDTH-1:0] a_q, b_q, bit_res, res;
  logic [2:0]       op_q;
  logic             s1_load, s2_load;

  // Each stage advances when it is empty or the stage after it is moving.
  assign s2_load  = !vld_pipe[2] || OutReady;
  assign s1_load  = !vld_pipe[1] || s2_load;
  assign InReady  = s1_load;
  assign OutValid = vld_pipe[2];

  for (genvar g = 0; g < WIDTH; g++) begin : g_slice
    logic_unit_slice u_slice (
      .a  (a_q[g]),
      .b  (b_q[g]),
      .op (op_q),
      .y  (bit_res[g])
    );
  end

`ifdef LOGIC_UNIT_POPCNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  logic [PW-1:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(a_q[i] & b_q[i]);
    res = (op_q == 3'b111) ? WIDTH'(pop) : bit_res;
  end
`else
  assign res = bit_res;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_pipe <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      Out      <= '0;
      Zero     <= 1'b0;
      AllOnes  <= 1'b0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= InValid;
        if (InValid) begin
          a_q  <= A;
          b_q  <= B;
          op_q <= Op;
        end
      end
      // A bubble moving into S2 clears the valid but leaves the result untouched.
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          Out     <= res;
          Zero    <= ~|res;
          AllOnes <= &res;
        end
      end
    end
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed vectors plus a short randomised handshake phase.
module tb_logic_unit_pipe;
  localparam int WIDTH = 32;

  logic             Clk = 1'b0;
  logic             Rst = 1'b1;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [2:0]       Op = '0;
  logic             OutValid;
  logic             OutReady = 1'b0;
  logic [WIDTH-1:0] Out;
  logic             Zero;
  logic             AllOnes;

  typedef struct {
    logic [WIDTH-1:0] out;
    int               issue;
    bit               lat_chk;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  bit               rdone = 1'b0;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0]       rop;

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .Op       (Op),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Out      (Out),
    .Zero     (Zero),
    .AllOnes  (AllOnes)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
`ifdef LOGIC_UNIT_POPCNT_EN
      default: return WIDTH'($countones(a & b));
`else
      default: return a;
`endif
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the item.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op,
                      input logic [WIDTH-1:0] exp, input bit lat_chk);
    int   n = 0;
    exp_t e;
    A = a; B = b; Op = op; InValid = 1'b1;
    @(negedge Clk);
    while (!InReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) begin
      checks++; errors++;
      $display("FAIL send_timeout: InReady got 0 expected 1 within 100 cycles");
      InValid = 1'b0;
      @(posedge Clk); #1;
      return;
    end
    e.out = exp; e.issue = cyc; e.lat_chk = lat_chk;
    sb.push_back(e);
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    @(posedge Clk); #1;
  endtask

  // Monitor: pops on every output transfer and checks results are held while stalled.
  initial begin
    logic [WIDTH-1:0] p_out;
    logic             p_z, p_a;
    bit               p_stall;
    exp_t             e;
    p_stall = 1'b0; p_out = '0; p_z = 1'b0; p_a = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        p_stall = 1'b0;
      end else begin
        if (p_stall)
          check("stall_hold", 64'({OutValid, Zero, AllOnes, Out}), 64'({1'b1, p_z, p_a, p_out}));
        if (OutValid && OutReady) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got %h expected no output", Out);
          end else begin
            e = sb.pop_front();
            check("result", 64'({Zero, AllOnes, Out}), 64'({e.out == '0, e.out == '1, e.out}));
            if (e.lat_chk) check("latency", 64'(cyc - e.issue), 64'd2);
          end
        end
        p_stall = OutValid && !OutReady;
        p_out = Out; p_z = Zero; p_a = AllOnes;
      end
    end
  end

  initial begin
    #2;
    check("rst_outvalid", 64'(OutValid), 64'd0);
    check("rst_out", 64'(Out), 64'd0);
    check("rst_flags", 64'({Zero, AllOnes}), 64'd0);
    @(negedge Clk); Rst = 1'b0;
    @(posedge Clk); #1;
    check("inready_after_rst", 64'(InReady), 64'd1);
    OutReady = 1'b1;

    // back-to-back AND/OR/XOR, 2-cycle latency, one per cycle
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b1);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'h0FF0_0FF0, 1'b1);
    drain();

    // backpressure: two items fill the pipe, third waits for OutReady
    OutReady = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'h0000_0000, 1'b0);
    send(32'h1234_5678, 32'h0000_0000, 3'b001, 32'h1234_5678, 1'b0);
    fork
      send(32'hAAAA_AAAA, 32'h5555_5555, 3'b010, 32'hFFFF_FFFF, 1'b0);
      begin
        repeat (4) @(negedge Clk);
        check("stall_inready", 64'(InReady), 64'd0);
        check("stall_out", 64'({OutValid, Zero, Out}), 64'({1'b1, 1'b1, 32'h0}));
        @(posedge Clk); #1;
        OutReady = 1'b1;
      end
    join
    drain();

    // remaining ops and flag boundaries
    send(32'h0000_0000, 32'h0000_0000, 3'b100, 32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 32'h0000_FFFF, 3'b110, 32'hFFFF_0000, 1'b0);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'h0FFF_0FFF, 1'b0);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h000F_000F, 1'b0);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'hF00F_F00F, 1'b0);
`ifdef LOGIC_UNIT_POPCNT_EN
    send(32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'b111, 32'd16, 1'b0);
`else
    send(32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'b111, 32'hFFFF_FFFF, 1'b0);
`endif
    drain();

    // reset with both stages occupied drops everything
    OutReady = 1'b0;
    send(32'h0000_00FF, 32'h0000_000F, 3'b000, 32'h0000_000F, 1'b0);
    send(32'h0000_00FF, 32'h0000_000F, 3'b001, 32'h0000_00FF, 1'b0);
    #2 Rst = 1'b1;
    #1;
    check("midrst_outvalid", 64'(OutValid), 64'd0);
    check("midrst_out", 64'({Zero, AllOnes, Out}), 64'd0);
    sb.delete();
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    check("midrst_inready", 64'(InReady), 64'd1);
    OutReady = 1'b1;
    repeat (8) @(negedge Clk);
    check("midrst_no_output", 64'(OutValid), 64'd0);
    @(posedge Clk); #1;

    // random handshake against the golden function
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge Clk); #1;
          end else begin
            ra = $urandom; rb = $urandom; rop = 3'($urandom_range(0, 7));
            send(ra, rb, rop, model(ra, rb, rop), 1'b0);
          end
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          OutReady = 1'($urandom_range(0, 1));
          @(posedge Clk); #1;
        end
        OutReady = 1'b1;
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation got no end expected finish before 2ms");
    $fatal(1, "watchdog");
  end
endmodule
